// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter: FSM states, owner tags
// and the default starvation limit used by the optional guard.
package imem_dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT_IF = 2'd1,
    ARB_WAIT_D  = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IF = 1'b0,
    ARB_OWN_D  = 1'b1
  } arb_owner_e;

  localparam int unsigned ARB_STARVE_MAX = 4;

  // Starvation counter is at least 3 bits wide, wider if the limit needs it.
  function automatic int unsigned starve_cnt_w(input int unsigned max_cnt);
    int unsigned w;
    w = $clog2(max_cnt + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [31:0]         if_rdata_o,
  output logic                if_wait_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wmask_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_wait_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  arb_state_e state_reg;
  logic       hi_reg;
  logic       force_if;
  logic       idle;
  arb_owner_e sel_owner;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = starve_cnt_w(STARVE_MAX);
  logic [CNT_W-1:0] starve_cnt_reg;

  assign force_if = (starve_cnt_reg >= CNT_W'(STARVE_MAX));

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_reg <= '0;
    end else if (!if_req_i || if_gnt_o) begin
      starve_cnt_reg <= '0;
    end else if (d_gnt_o && (starve_cnt_reg < CNT_W'(STARVE_MAX))) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  assign idle = (state_reg == ARB_IDLE) && !reset;

  // Data wins unless the guard has tripped and fetch is actually asking.
  assign sel_owner = (d_req_i && !(force_if && if_req_i)) ? ARB_OWN_D : ARB_OWN_IF;

  assign mem_req_o = idle && (if_req_i || d_req_i);

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (mem_req_o) begin
      if (sel_owner == ARB_OWN_D) begin
        mem_we_o    = d_we_i;
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
        mem_wmask_o = d_wmask_i;
      end else begin
        mem_addr_o  = if_addr_i;
      end
    end
  end

  assign if_gnt_o = mem_req_o && mem_gnt_i && (sel_owner == ARB_OWN_IF);
  assign d_gnt_o  = mem_req_o && mem_gnt_i && (sel_owner == ARB_OWN_D);

  // Responses are only routed while a transaction is outstanding.
  assign if_rvalid_o = !reset && (state_reg == ARB_WAIT_IF) && mem_rvalid_i;
  assign d_rvalid_o  = !reset && (state_reg == ARB_WAIT_D) && mem_rvalid_i;

  assign if_rdata_o = reset  ? 32'd0 :
                      hi_reg ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
  assign d_rdata_o  = reset ? '0 : mem_rdata_i;

  assign if_wait_o = !reset &&
                     (((state_reg != ARB_WAIT_IF) && if_req_i) ||
                      ((state_reg == ARB_WAIT_IF) && !mem_rvalid_i));
  assign d_wait_o  = !reset &&
                     (((state_reg != ARB_WAIT_D) && d_req_i) ||
                      ((state_reg == ARB_WAIT_D) && !mem_rvalid_i));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ARB_IDLE;
      hi_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (mem_req_o && mem_gnt_i) begin
            state_reg <= (sel_owner == ARB_OWN_D) ? ARB_WAIT_D : ARB_WAIT_IF;
            hi_reg    <= if_addr_i[2];
          end
        end
        ARB_WAIT_IF, ARB_WAIT_D: begin
          if (mem_rvalid_i) begin
            state_reg <= ARB_IDLE;
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

endmodule
